// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ valid/ready command ports onto one APB slave,
// sequences SETUP/ACCESS, and returns read data or a timeout error to the winning requester.
module apb_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               any_valid;
  logic [IDX_W-1:0]   grant_idx;

  // Scan from farthest to nearest after the last winner so the nearest requester wins.
  always_comb begin
    int cand;
    cand      = 0;
    any_valid = 1'b0;
    grant_idx = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (req_valid[IDX_W'(cand)]) begin
        grant_idx = IDX_W'(cand);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && any_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wait_d      = wait_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d   = ST_SETUP;
          last_d    = grant_idx;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write[grant_idx];
          paddr_d   = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          pwdata_d  = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end

      ST_ACCESS: begin
        if (pready) begin
          state_d             = ST_IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b0;
          rsp_rdata_d         = pwrite_q ? '0 : prdata;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          // Last permitted ACCESS cycle elapsed without pready: abort with an error.
          state_d             = ST_IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b1;
          rsp_rdata_d         = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wait_q      <= wait_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
